ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, RAM address width.
REQ-002 SHALL have parameter: DATA_W, 8, RAM data width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high: i_clk  in  1  clock, rising-edge.
REQ-004 SHALL have port: i_reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports: i_aReq in 1 / i_aWe in 1 / i_aAddr in ADDR_W / i_aData in DATA_W; requester A (CPU) access request, write flag, address, write data.
REQ-006 SHALL have ports: o_aAck out 1 / o_aRdData out DATA_W; A completion pulse, read data.
REQ-007 SHALL have ports: i_bReq, i_bWe, i_bAddr, i_bData, o_bAck, o_bRdData; requester B (program loader/debug), same widths and meaning as A.
REQ-008 SHALL have ports: o_ramEn out 1 / o_ramWe out 1 / o_ramAddr out ADDR_W / o_ramData out DATA_W / i_ramData in DATA_W; single synchronous RAM port, 1-cycle read latency.
REQ-009 SHALL have port: o_busy  out  1  high when state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, ACCESS, RESP; all outputs registered.
REQ-011 Requester handshake SHALL be: Req held high with stable We/Addr/Data until its Ack is seen; Ack is a one-cycle pulse.
REQ-012 In IDLE, a requester is eligible iff its Req=1 and its Ack is currently 0.
REQ-013 At a rising edge in IDLE with >=1 eligible requester, SHALL latch the winner's We/Addr/Data and id, go to ACCESS.
REQ-014 Single eligible requester SHALL win; with both eligible, round-robin: winner = requester not served last.
REQ-015 Last-served flag SHALL update at each IDLE->ACCESS transition.
REQ-016 During ACCESS: o_ramEn=1, o_ramWe=latched We, o_ramAddr/o_ramData=latched values; next edge -> RESP.
REQ-017 During RESP: o_ramEn=0, o_ramWe=0; next edge SHALL load winner's RdData from i_ramData (reads only; writes leave RdData unchanged), pulse winner's Ack for one cycle, -> IDLE.
REQ-018 Latency: Req sampled at edge k -> RAM access cycle k..k+1 -> Ack high in cycle after edge k+2 (3 cycles request-to-ack).
REQ-019 The non-winning requester's Ack and RdData SHALL be unchanged during any transaction.
REQ-020 Requester whose Ack is high SHALL not be granted that cycle; the other requester may be granted at the same edge (back-to-back interleave).
REQ-021 o_ramWe SHALL never be 1 while o_ramEn=0.
REQ-022 Req changes during ACCESS/RESP SHALL not affect the in-flight transaction.
REQ-023 No requester SHALL wait more than one foreign transaction while continuously eligible.

Reset
REQ-024 On i_reset=1 SHALL immediately (asynchronously) force state IDLE, o_ramEn=0, o_ramWe=0, o_ramAddr=0, o_ramData=0, o_aAck=o_bAck=0, o_aRdData=o_bRdData=0, o_busy=0.
REQ-025 Reset SHALL set last-served = B, so A wins first contended arbitration.
REQ-026 Reset mid-transaction SHALL abort it with no Ack; the aborted write may or may not have reached RAM only if reset occurs after the ACCESS edge.
REQ-027 First arbitration SHALL occur at first rising edge with i_reset=0.

Verification
REQ-028 A read alone: i_aReq=1, We=0, Addr=0x12, RAM holds 0x5A -> o_ramEn 1 cycle with addr 0x12, o_aAck pulse 3 cycles later, o_aRdData=0x5A, o_bAck stays 0.
REQ-029 B write: i_bWe=1, Addr=0x80, Data=0xC3 -> one cycle o_ramEn=1, o_ramWe=1, addr 0x80, data 0xC3; o_bAck pulse; subsequent A read of 0x80 returns 0xC3.
REQ-030 Both requesting continuously from reset -> grant order A,B,A,B; each Ack 1 cycle; RAM access every 3rd cycle.
REQ-031 A holds Req through its Ack cycle, B idle -> A not re-granted during Ack cycle; new A transaction only if Req still high the cycle after.
REQ-032 Assert i_reset asynchronously during ACCESS of a write -> o_ramEn/o_ramWe drop before next clock edge, no Ack, o_busy=0; after release, A read completes normally.
REQ-033 B requests during A's RESP -> B granted at A's Ack edge; B Ack exactly 3 cycles later.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving two requesters (A = CPU, B = loader/debug) one synchronous single-port RAM.
// Latency: Req sampled at edge k, RAM enabled for cycle k..k+1, Ack pulse (and read data) after edge k+2.
// Backpressure: one transaction in flight; a requester holds Req with stable fields until its Ack pulse.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_aReq,
  input  logic              i_aWe,
  input  logic [ADDR_W-1:0] i_aAddr,
  input  logic [DATA_W-1:0] i_aData,
  output logic              o_aAck,
  output logic [DATA_W-1:0] o_aRdData,
  input  logic              i_bReq,
  input  logic              i_bWe,
  input  logic [ADDR_W-1:0] i_bAddr,
  input  logic [DATA_W-1:0] i_bData,
  output logic              o_bAck,
  output logic [DATA_W-1:0] o_bRdData,
  output logic              o_ramEn,
  output logic              o_ramWe,
  output logic [ADDR_W-1:0] o_ramAddr,
  output logic [DATA_W-1:0] o_ramData,
  input  logic [DATA_W-1:0] i_ramData,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, stateNext;
  logic                winB, winBNext;     // id of the in-flight winner (1 = B)
  logic                lastB, lastBNext;   // last-served requester (1 = B)
  logic                latWe, latWeNext;   // write flag of the in-flight transaction
  logic                aElig, bElig, pickB;
  logic                ramEnNext, ramWeNext, aAckNext, bAckNext, busyNext;
  logic [ADDR_W-1:0]   ramAddrNext;
  logic [DATA_W-1:0]   ramDataNext, aRdNext, bRdNext;

  // Arbitration and next-state/next-output computation; every output is registered from these
  always_comb begin
    stateNext   = state;
    winBNext    = winB;
    lastBNext   = lastB;
    latWeNext   = latWe;
    ramEnNext   = 1'b0;
    ramWeNext   = 1'b0;
    ramAddrNext = o_ramAddr;
    ramDataNext = o_ramData;
    aAckNext    = 1'b0;
    bAckNext    = 1'b0;
    aRdNext     = o_aRdData;
    bRdNext     = o_bRdData;
    busyNext    = 1'b0;
    // A requester still showing its Ack is finishing the previous handshake, so it is skipped
    aElig       = i_aReq & ~o_aAck;
    bElig       = i_bReq & ~o_bAck;
    // B wins if it is the only one asking, or if both ask and A was served last
    pickB       = bElig & (~aElig | ~lastB);
    case (state)
      IDLE: begin
        if (aElig | bElig) begin
          stateNext   = ACCESS;
          winBNext    = pickB;
          lastBNext   = pickB;
          latWeNext   = pickB ? i_bWe : i_aWe;
          ramEnNext   = 1'b1;
          ramWeNext   = pickB ? i_bWe : i_aWe;
          ramAddrNext = pickB ? i_bAddr : i_aAddr;
          ramDataNext = pickB ? i_bData : i_aData;
          busyNext    = 1'b1;
        end
      end
      ACCESS: begin
        stateNext = RESP;
        busyNext  = 1'b1;
      end
      RESP: begin
        // RAM read data is valid during RESP (one cycle after the enabled edge)
        stateNext = IDLE;
        if (winB) begin
          bAckNext = 1'b1;
          if (!latWe) bRdNext = i_ramData;
        end else begin
          aAckNext = 1'b1;
          if (!latWe) aRdNext = i_ramData;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction and favours A for the first contest
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      winB      <= 1'b0;
      lastB     <= 1'b1;
      latWe     <= 1'b0;
      o_ramEn   <= 1'b0;
      o_ramWe   <= 1'b0;
      o_ramAddr <= '0;
      o_ramData <= '0;
      o_aAck    <= 1'b0;
      o_bAck    <= 1'b0;
      o_aRdData <= '0;
      o_bRdData <= '0;
      o_busy    <= 1'b0;
    end else begin
      state     <= stateNext;
      winB      <= winBNext;
      lastB     <= lastBNext;
      latWe     <= latWeNext;
      o_ramEn   <= ramEnNext;
      o_ramWe   <= ramWeNext;
      o_ramAddr <= ramAddrNext;
      o_ramData <= ramDataNext;
      o_aAck    <= aAckNext;
      o_bAck    <= bAckNext;
      o_aRdData <= aRdNext;
      o_bRdData <= bRdNext;
      o_busy    <= busyNext;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a transaction-timing reference model.
// Latency: model expects RAM enable at the grant edge, Ack three edges after the request is sampled.
// Backpressure: bench requesters hold Req and fields until their Ack, then drop or reissue.
module tb_ram_arbiter;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_aReq = 1'b0, i_aWe = 1'b0;
  logic [7:0] i_aAddr = '0, i_aData = '0;
  logic       i_bReq = 1'b0, i_bWe = 1'b0;
  logic [7:0] i_bAddr = '0, i_bData = '0;
  logic       o_aAck, o_bAck, o_ramEn, o_ramWe, o_busy;
  logic [7:0] o_aRdData, o_bRdData, o_ramAddr, o_ramData;
  logic [7:0] ramQ = '0;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_aReq(i_aReq), .i_aWe(i_aWe), .i_aAddr(i_aAddr), .i_aData(i_aData),
    .o_aAck(o_aAck), .o_aRdData(o_aRdData),
    .i_bReq(i_bReq), .i_bWe(i_bWe), .i_bAddr(i_bAddr), .i_bData(i_bData),
    .o_bAck(o_bAck), .o_bRdData(o_bRdData),
    .o_ramEn(o_ramEn), .o_ramWe(o_ramWe), .o_ramAddr(o_ramAddr), .o_ramData(o_ramData),
    .i_ramData(ramQ), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Power-on RAM contents: location 0x12 holds 0x5A, others a simple address pattern
  function automatic logic [7:0] memInit(input logic [7:0] a);
    return (a == 8'h12) ? 8'h5A : 8'(a * 3 + 1);
  endfunction

  // Synchronous RAM with one-cycle read latency
  bit [7:0] mem [256];
  bit       memVld [256];
  always @(posedge i_clk) begin
    if (o_ramEn) begin
      if (o_ramWe) begin
        mem[o_ramAddr]    <= o_ramData;
        memVld[o_ramAddr] <= 1'b1;
      end
      ramQ <= memVld[o_ramAddr] ? mem[o_ramAddr] : memInit(o_ramAddr);
    end
  end

  // Reference model state
  int         nCmp = 0, nFail = 0;
  int         edgeNo = 0;
  int         gEdge = -100;
  logic       gB = 1'b0, gWe = 1'b0, lastB = 1'b1;
  logic [7:0] gAddr = '0, gData = '0, oldVal = '0;
  logic       expAckA = 1'b0, expAckB = 1'b0;
  logic [7:0] expRdA = '0, expRdB = '0;
  logic [7:0] refMem [256];
  logic       grants [$];
  int         grantEdges [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict grant from pre-edge inputs, then compare every output after the edge
  task automatic step();
    logic eligA, eligB, wB;
    eligA = i_aReq && !expAckA;
    eligB = i_bReq && !expAckB;
    if (!i_reset && edgeNo >= gEdge + 3 && (eligA || eligB)) begin
      wB     = eligB && (!eligA || !lastB);
      lastB  = wB;
      gEdge  = edgeNo;
      gB     = wB;
      gWe    = wB ? i_bWe : i_aWe;
      gAddr  = wB ? i_bAddr : i_aAddr;
      gData  = wB ? i_bData : i_aData;
      oldVal = refMem[gAddr];
      if (gWe) refMem[gAddr] = gData;
      grants.push_back(wB);
      grantEdges.push_back(edgeNo);
    end
    @(posedge i_clk);
    #1;
    expAckA = 1'b0;
    expAckB = 1'b0;
    if (edgeNo == gEdge + 2) begin
      if (gB) begin
        expAckB = 1'b1;
        if (!gWe) expRdB = refMem[gAddr];
      end else begin
        expAckA = 1'b1;
        if (!gWe) expRdA = refMem[gAddr];
      end
    end
    check("ramEn", o_ramEn, edgeNo == gEdge);
    check("ramWe", o_ramWe, (edgeNo == gEdge) && gWe);
    if (edgeNo == gEdge) begin
      check("ramAddr", o_ramAddr, gAddr);
      if (gWe) check("ramData", o_ramData, gData);
    end
    check("busy", o_busy, (edgeNo == gEdge) || (edgeNo == gEdge + 1));
    check("aAck", o_aAck, expAckA);
    check("bAck", o_bAck, expAckB);
    check("aRdData", o_aRdData, expRdA);
    check("bRdData", o_bRdData, expRdB);
    edgeNo++;
  endtask

  task automatic newA();
    i_aReq = 1'b1; i_aWe = 1'($urandom_range(0, 1));
    i_aAddr = 8'($urandom_range(0, 127)); i_aData = 8'($urandom);
  endtask

  task automatic newB();
    i_bReq = 1'b1; i_bWe = 1'($urandom_range(0, 1));
    i_bAddr = 8'($urandom_range(0, 127)); i_bData = 8'($urandom);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 256; i++) refMem[i] = memInit(8'(i));

    // Reset state
    @(posedge i_clk);
    #1;
    check("rst_ramEn", o_ramEn, 0);
    check("rst_ramWe", o_ramWe, 0);
    check("rst_ramAddr", o_ramAddr, 0);
    check("rst_ramData", o_ramData, 0);
    check("rst_acks", {o_aAck, o_bAck}, 0);
    check("rst_rd", {o_aRdData, o_bRdData}, 0);
    check("rst_busy", o_busy, 0);
    edgeNo++;
    #2 i_reset = 1'b0;

    // Both requesting continuously from reset: A,B,A,B every third edge
    base = grants.size();
    i_aReq = 1'b1; i_aWe = 1'b0; i_aAddr = 8'h12;
    i_bReq = 1'b1; i_bWe = 1'b0; i_bAddr = 8'h13;
    for (int i = 0; i < 12; i++) step();
    i_aReq = 1'b0; i_bReq = 1'b0;
    check("rr_count", grants.size() - base, 4);
    check("rr_order", {grants[base], grants[base+1], grants[base+2], grants[base+3]}, 4'b0101);
    check("rr_first_edge", grantEdges[base], 1);
    check("rr_spacing", grantEdges[base+3] - grantEdges[base], 9);
    step(); step();

    // A read alone of 0x12
    i_aReq = 1'b1; i_aWe = 1'b0; i_aAddr = 8'h12;
    step();
    check("rd_addr", o_ramAddr, 8'h12);
    step(); step();
    check("rd_ack", o_aAck, 1);
    check("rd_data", o_aRdData, 8'h5A);
    i_aReq = 1'b0;
    step(); step();

    // B write 0xC3 to 0x80, then A reads it back
    i_bReq = 1'b1; i_bWe = 1'b1; i_bAddr = 8'h80; i_bData = 8'hC3;
    step();
    check("wr_port", {o_ramEn, o_ramWe, o_ramAddr, o_ramData}, {2'b11, 8'h80, 8'hC3});
    step(); step();
    check("wr_ack", o_bAck, 1);
    i_bReq = 1'b0;
    i_aReq = 1'b1; i_aWe = 1'b0; i_aAddr = 8'h80;
    step(); step(); step(); step();
    check("wr_readback", o_aRdData, 8'hC3);
    i_aReq = 1'b0;
    step();

    // A holds Req through its Ack cycle with B idle: re-grant one edge after the Ack cycle
    base = grants.size();
    i_aReq = 1'b1; i_aWe = 1'b0; i_aAddr = 8'h21;
    for (int i = 0; i < 8; i++) step();
    i_aReq = 1'b0;
    check("hold_count", grants.size() - base, 2);
    check("hold_gap", grantEdges[base+1] - grantEdges[base], 4);
    step();

    // B raises Req during A's RESP: granted at the edge closing A's Ack cycle
    base = grants.size();
    i_aReq = 1'b1; i_aWe = 1'b0; i_aAddr = 8'h30;
    step(); step();
    i_bReq = 1'b1; i_bWe = 1'b0; i_bAddr = 8'h12;
    step();
    i_aReq = 1'b0;
    step(); step(); step();
    check("interleave_gap", grantEdges[base+1] - grantEdges[base], 3);
    check("interleave_bAck", o_bAck, 1);
    check("interleave_bRd", o_bRdData, 8'h5A);
    i_bReq = 1'b0;
    step();

    // Asynchronous reset during the ACCESS cycle of a write
    i_aReq = 1'b1; i_aWe = 1'b1; i_aAddr = 8'h12; i_aData = 8'hEE;
    step();
    #2 i_reset = 1'b1;
    #1;
    check("abort_port", {o_ramEn, o_ramWe}, 0);
    check("abort_busy", o_busy, 0);
    check("abort_acks", {o_aAck, o_bAck}, 0);
    i_aReq = 1'b0;
    if (gWe) refMem[gAddr] = oldVal;
    gEdge = -100; lastB = 1'b1; expRdA = '0; expRdB = '0;
    step();
    #2 i_reset = 1'b0;
    i_aReq = 1'b1; i_aWe = 1'b0; i_aAddr = 8'h12;
    step(); step(); step();
    check("post_reset_ack", o_aAck, 1);
    check("post_reset_rd", o_aRdData, 8'h5A);
    i_aReq = 1'b0;
    step();

    // Randomized traffic from both requesters
    for (int c = 0; c < 400; c++) begin
      if (!i_aReq) begin
        if ($urandom_range(0, 2) == 0) newA();
      end else if (expAckA) begin
        if ($urandom_range(0, 1) == 0) i_aReq = 1'b0; else newA();
      end
      if (!i_bReq) begin
        if ($urandom_range(0, 2) == 0) newB();
      end else if (expAckB) begin
        if ($urandom_range(0, 1) == 0) i_bReq = 1'b0; else newB();
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
